// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the microcoded CPU control path.
//   UOP_W       width of the microoperation step bus
//   UOP_FETCH   first step of every instruction
//   UOP_DECODE  second step of every instruction
//   UOP_IDLE    step presented to the ROM while the sequencer is halted
//   seq_state_t run/halt/single-step sequencer states
package cpu_ctrl_pkg;

  localparam int unsigned UOP_W = 3;

  localparam logic [UOP_W-1:0] UOP_FETCH  = 3'd0;
  localparam logic [UOP_W-1:0] UOP_DECODE = 3'd1;
  localparam logic [UOP_W-1:0] UOP_IDLE   = 3'd7;

  typedef enum logic [1:0] {
    SEQ_HALTED = 2'd0,
    SEQ_RUN    = 2'd1,
    SEQ_STEP   = 2'd2
  } seq_state_t;

  // True while an instruction is being executed (free-run or single-step).
  function automatic logic seq_active(input seq_state_t s);
    return (s == SEQ_RUN) || (s == SEQ_STEP);
  endfunction

endpackage

// File: rtl/step_edge_detect.sv
// step_edge_detect: registers the STEP push-button level and flags its rising edge.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset; history clears to 0
//   sig   in  level to watch
//   rise  out 1 in the cycle where sig is 1 and was 0 at the previous edge
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/microop_sequencer.sv
// microop_sequencer: drives the microoperation step into the controller ROM,
// owns run/halt/single-step control and the registered ALU flags.
// Parameters:
//   MAX_UOP  highest legal executing step (implicit instruction boundary)
//   COUNT_W  width of the retired-instruction counter (wraps)
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-high reset
//   RUN                   1 = free-run, 0 = stop at next instruction boundary
//   STEP                  rising edge while halted runs exactly one instruction
//   HALT_REQ              forces halt at next boundary, blocks leaving HALTED
//   RESET_uOP, READ_FLAGS end-of-instruction / flag-capture strobes from ROM
//   ALU_ZERO, ALU_COUT    raw ALU flags
//   uOP                   current step to ROM (7 while halted)
//   ZERO_FLAG, COUT_FLAG  registered flags
//   RUNNING               1 in RUN or STEP state
//   INSTR_DONE            one-cycle pulse after each retired instruction
//   INSTR_COUNT           retired instruction count
//   FAULT                 sticky runaway-microcode flag
// Build option: define UOP_WATCHDOG_EN to turn reaching MAX_UOP without
// RESET_uOP into a sticky fault that halts the sequencer; otherwise that
// condition is an ordinary instruction boundary and FAULT is tied 0.
module microop_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_UOP = 6,
  parameter int COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               RUN,
  input  logic               STEP,
  input  logic               HALT_REQ,
  input  logic               RESET_uOP,
  input  logic               READ_FLAGS,
  input  logic               ALU_ZERO,
  input  logic               ALU_COUT,
  output logic [UOP_W-1:0]   uOP,
  output logic               ZERO_FLAG,
  output logic               COUT_FLAG,
  output logic               RUNNING,
  output logic               INSTR_DONE,
  output logic [COUNT_W-1:0] INSTR_COUNT,
  output logic               FAULT
);

  localparam logic [UOP_W-1:0] LAST_STEP = UOP_W'(MAX_UOP);

  seq_state_t             state_q, state_d;
  logic [UOP_W-1:0]       uop_q, uop_d;
  logic                   zero_q, cout_q;
  logic                   done_q;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic                   step_rise;
  logic                   active;
  logic                   at_last;
  logic                   boundary;
  logic                   runaway;
  logic                   exit_blocked;
  logic                   retire;
  logic                   load_flags;

  step_edge_detect u_step_edge (
    .clk  (CLK),
    .rst  (RESET),
    .sig  (STEP),
    .rise (step_rise)
  );

  assign active  = seq_active(state_q);
  assign at_last = (uop_q == LAST_STEP);

`ifdef UOP_WATCHDOG_EN
  logic fault_q;

  assign boundary     = RESET_uOP;
  assign runaway      = active && at_last && !RESET_uOP;
  assign exit_blocked = HALT_REQ || fault_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fault_q <= 1'b0;
    end else if (runaway) begin
      fault_q <= 1'b1;
    end
  end

  assign FAULT = fault_q;
`else
  assign boundary     = RESET_uOP || at_last;
  assign runaway      = 1'b0;
  assign exit_blocked = HALT_REQ;
  assign FAULT        = 1'b0;
`endif

  // State register plus the registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= SEQ_HALTED;
      uop_q   <= UOP_IDLE;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      uop_q   <= uop_d;
      done_q  <= retire;
      count_q <= count_d;
      if (load_flags) begin
        zero_q <= ALU_ZERO;
        cout_q <= ALU_COUT;
      end
    end
  end

  // Next-state and next-step decode.
  always_comb begin
    state_d = state_q;
    uop_d   = uop_q;
    retire  = 1'b0;
    unique case (state_q)
      SEQ_HALTED: begin
        uop_d = UOP_IDLE;
        if (!exit_blocked) begin
          if (RUN) begin
            state_d = SEQ_RUN;
            uop_d   = UOP_FETCH;
          end else if (step_rise) begin
            state_d = SEQ_STEP;
            uop_d   = UOP_FETCH;
          end
        end
      end
      SEQ_RUN, SEQ_STEP: begin
        if (runaway) begin
          state_d = SEQ_HALTED;
          uop_d   = UOP_IDLE;
        end else if (boundary) begin
          retire = 1'b1;
          // Only a free-running sequencer continues; single-step always parks.
          if (state_q == SEQ_RUN && RUN && !HALT_REQ) begin
            uop_d = UOP_FETCH;
          end else begin
            state_d = SEQ_HALTED;
            uop_d   = UOP_IDLE;
          end
        end else begin
          uop_d = uop_q + UOP_W'(1);
        end
      end
      default: begin
        state_d = SEQ_HALTED;
        uop_d   = UOP_IDLE;
      end
    endcase
  end

  // Output decode feeding the registered outputs.
  always_comb begin
    load_flags = active && READ_FLAGS;
    count_d    = count_q;
    if (retire) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  assign uOP         = uop_q;
  assign ZERO_FLAG   = zero_q;
  assign COUT_FLAG   = cout_q;
  assign RUNNING     = active;
  assign INSTR_DONE  = done_q;
  assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_microop_sequencer.sv
// tb_microop_sequencer: directed self-checking bench for microop_sequencer.
// COUNT_W is reduced so the counter wrap is reachable in a short run.
module tb_microop_sequencer;

  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          run;
  logic          step;
  logic          halt_req;
  logic          reset_uop;
  logic          read_flags;
  logic          alu_zero;
  logic          alu_cout;
  logic [2:0]    uop;
  logic          zero_flag;
  logic          cout_flag;
  logic          running;
  logic          instr_done;
  logic [CW-1:0] instr_count;
  logic          fault;

  int checks = 0;
  int errors = 0;

  microop_sequencer #(
    .MAX_UOP (6),
    .COUNT_W (CW)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .RUN         (run),
    .STEP        (step),
    .HALT_REQ    (halt_req),
    .RESET_uOP   (reset_uop),
    .READ_FLAGS  (read_flags),
    .ALU_ZERO    (alu_zero),
    .ALU_COUT    (alu_cout),
    .uOP         (uop),
    .ZERO_FLAG   (zero_flag),
    .COUT_FLAG   (cout_flag),
    .RUNNING     (running),
    .INSTR_DONE  (instr_done),
    .INSTR_COUNT (instr_count),
    .FAULT       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_uop"},   32'(uop), 32'd7);
    chk({tag, "_zero"},  32'(zero_flag), 32'd0);
    chk({tag, "_cout"},  32'(cout_flag), 32'd0);
    chk({tag, "_run"},   32'(running), 32'd0);
    chk({tag, "_done"},  32'(instr_done), 32'd0);
    chk({tag, "_count"}, 32'(instr_count), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    reset_uop = 1'b0; read_flags = 1'b0; alu_zero = 1'b0; alu_cout = 1'b0;

    #2;
    chk_reset_values("reset");
    tick();
    rst = 1'b0;

    // Free run, boundary at step 3: 7,0,1,2,3,0,1,2,3...
    run = 1'b1;
    tick();
    chk("t1_entry_uop", 32'(uop), 32'd0);
    chk("t1_entry_running", 32'(running), 32'd1);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) begin
        chk("t1_uop", 32'(uop), 32'(j));
        if (j == 1) chk("t1_done_low", 32'(instr_done), 32'd0);
        reset_uop = (j == 3);
        tick();
        reset_uop = 1'b0;
        if (j == 3) begin
          chk("t1_count", 32'(instr_count), 32'(i + 1));
          chk("t1_done_pulse", 32'(instr_done), 32'd1);
        end
      end
    end
    // Drop RUN: the current instruction finishes, then park.
    run = 1'b0;
    tick();
    tick();
    chk("t1_tail_uop", 32'(uop), 32'd2);
    reset_uop = 1'b1;
    tick();
    reset_uop = 1'b0;
    chk("t1_halt_uop", 32'(uop), 32'd7);
    chk("t1_halt_running", 32'(running), 32'd0);
    chk("t1_halt_count", 32'(instr_count), 32'd4);

    // Single step, boundary at step 4, flags captured there.
    step = 1'b1;
    tick();
    chk("t2_uop0", 32'(uop), 32'd0);
    chk("t2_running", 32'(running), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t2_uop", 32'(uop), 32'(k));
    end
    reset_uop = 1'b1; read_flags = 1'b1; alu_zero = 1'b1; alu_cout = 1'b0;
    tick();
    reset_uop = 1'b0; read_flags = 1'b0; alu_zero = 1'b0; alu_cout = 1'b1;
    chk("t2_park_uop", 32'(uop), 32'd7);
    chk("t2_count", 32'(instr_count), 32'd5);
    chk("t3_zero_capt", 32'(zero_flag), 32'd1);
    chk("t3_cout_capt", 32'(cout_flag), 32'd0);
    // STEP still held high: no second edge, no further run.
    tick();
    tick();
    chk("t2_held_uop", 32'(uop), 32'd7);
    chk("t2_held_running", 32'(running), 32'd0);
    chk("t2_held_count", 32'(instr_count), 32'd5);
    chk("t2_held_done", 32'(instr_done), 32'd0);
    step = 1'b0;

    // Flags survive halt and re-run until the next READ_FLAGS.
    run = 1'b1;
    tick();
    tick();
    chk("t3_rerun_uop", 32'(uop), 32'd1);
    chk("t3_zero_hold", 32'(zero_flag), 32'd1);
    chk("t3_cout_hold", 32'(cout_flag), 32'd0);
    read_flags = 1'b1;
    tick();
    read_flags = 1'b0;
    chk("t3_zero_new", 32'(zero_flag), 32'd0);
    chk("t3_cout_new", 32'(cout_flag), 32'd1);

    // HALT_REQ raised at step 2: instruction finishes, then parks.
    chk("t4_uop2", 32'(uop), 32'd2);
    halt_req = 1'b1;
    tick();
    chk("t4_uop3", 32'(uop), 32'd3);
    chk("t4_still_running", 32'(running), 32'd1);
    reset_uop = 1'b1;
    tick();
    reset_uop = 1'b0;
    chk("t4_park_uop", 32'(uop), 32'd7);
    chk("t4_park_running", 32'(running), 32'd0);
    chk("t4_count", 32'(instr_count), 32'd6);
    tick();
    tick();
    chk("t4_blocked_uop", 32'(uop), 32'd7);
    halt_req = 1'b0;
    tick();
    chk("t4_restart_uop", 32'(uop), 32'd0);
    chk("t4_restart_running", 32'(running), 32'd1);

    // No RESET_uOP: runs up to MAX_UOP.
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t5_uop", 32'(uop), 32'(k));
    end
    tick();
`ifdef UOP_WATCHDOG_EN
    chk("t5_wd_uop", 32'(uop), 32'd7);
    chk("t5_wd_fault", 32'(fault), 32'd1);
    chk("t5_wd_count", 32'(instr_count), 32'd6);
    chk("t5_wd_running", 32'(running), 32'd0);
    tick();
    chk("t5_wd_stuck_uop", 32'(uop), 32'd7);
    chk("t5_wd_stuck_fault", 32'(fault), 32'd1);
`else
    chk("t5_wrap_uop", 32'(uop), 32'd0);
    chk("t5_count", 32'(instr_count), 32'd7);
    chk("t5_done", 32'(instr_done), 32'd1);
    chk("t5_fault", 32'(fault), 32'd0);
`endif

    // Fresh reset, then one-cycle instructions to reach the count maximum.
    run = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_values("rst2");
    run = 1'b1; reset_uop = 1'b1; read_flags = 1'b1; alu_zero = 1'b1; alu_cout = 1'b1;
    tick();
    chk("t6_entry_count", 32'(instr_count), 32'd0);
    chk("t6_entry_zero", 32'(zero_flag), 32'd0);
    repeat (255) tick();
    chk("t6_count_max", 32'(instr_count), 32'd255);
    chk("t6_zero", 32'(zero_flag), 32'd1);
    chk("t6_cout", 32'(cout_flag), 32'd1);
    reset_uop = 1'b0; read_flags = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_uop3", 32'(uop), 32'd3);
    // Asynchronous reset mid-instruction, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("async");
    tick();
    rst = 1'b0;
    run = 1'b0;

    // Separate run: count wraps from maximum to 0.
    run = 1'b1; reset_uop = 1'b1;
    tick();
    repeat (255) tick();
    chk("t6b_count_max", 32'(instr_count), 32'd255);
    tick();
    chk("t6b_count_wrap", 32'(instr_count), 32'd0);
    chk("t6b_done", 32'(instr_done), 32'd1);
    chk("t6b_uop", 32'(uop), 32'd0);
    run = 1'b0; reset_uop = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/microop_sequencer.md
# microop_sequencer

Sequencer that drives the 3-bit microoperation step (`uOP`) into the microcoded controller ROM and owns the CPU's run/halt/single-step control and the ALU flag register. It advances `uOP` each clock, restarts it at 0 when the ROM signals end-of-instruction via `RESET_uOP`, and parks it in the ROM's idle step (7) while halted. It latches `ZERO_FLAG`/`COUT_FLAG` when the ROM asserts `READ_FLAGS`.

## Interface
- `MAX_UOP`, 6: highest legal executing step; reaching it without `RESET_uOP` is an implicit boundary (or fault, see Configuration).
- `COUNT_W`, 16: width of retired-instruction counter.
- `CLK`  in  1  system clock, rising edge.
- `RESET`  in  1  reset; one clock; asynchronous and active-high.
- `RUN`  in  1  level; 1 = free-run, 0 = stop at next instruction boundary.
- `STEP`  in  1  rising edge while halted and `RUN`=0 executes exactly one instruction.
- `HALT_REQ`  in  1  level; forces halt at next boundary regardless of `RUN`.
- `RESET_uOP`  in  1  from ROM; end of current instruction.
- `READ_FLAGS`  in  1  from ROM; capture ALU flags this edge.
- `ALU_ZERO`, `ALU_COUT`  in  1 each  raw ALU flags.
- `uOP`  out  3  current microoperation step to ROM.
- `ZERO_FLAG`, `COUT_FLAG`  out  1 each  registered flags to ROM.
- `RUNNING`  out  1  1 in RUN or STEP state.
- `INSTR_DONE`  out  1  one-cycle pulse after each retired instruction.
- `INSTR_COUNT`  out  `COUNT_W`  retired instructions, wraps.
- `FAULT`  out  1  sticky runaway-microcode flag (0 constant without macro).

## Operation
- States: HALTED, RUN, STEP. Reset: HALTED, `uOP`=7, flags 0, `RUNNING`=0, `INSTR_DONE`=0, `INSTR_COUNT`=0, `FAULT`=0, step-edge history 0.
- HALTED: `uOP` held 7; `RESET_uOP` and `READ_FLAGS` ignored. `RUN`=1 -> RUN, `uOP`=0. Else `STEP` rising edge -> STEP, `uOP`=0. `RUN` and `STEP` edge together: RUN wins. `HALT_REQ`=1 blocks both exits.
- RUN/STEP: `uOP` increments each cycle. Boundary = `RESET_uOP`=1, or `uOP`=`MAX_UOP` (no macro). At boundary: `INSTR_COUNT`+1, `INSTR_DONE` pulses next cycle; then STEP -> HALTED (`uOP`=7); RUN with `RUN`=1 and `HALT_REQ`=0 -> `uOP`=0; otherwise -> HALTED (`uOP`=7).
- `STEP` edges outside HALTED are discarded (no queuing).
- Flags: edge with `READ_FLAGS`=1 in RUN/STEP loads `ZERO_FLAG`<=`ALU_ZERO`, `COUT_FLAG`<=`ALU_COUT`; otherwise hold. Flags survive halt; cleared only by `RESET`.
- `RESET` mid-instruction: immediate return to reset values; partial instruction abandoned.

## Timing
- All outputs registered; no combinational input-to-output path.
- HALTED -> first fetch: `uOP`=0 the cycle after the edge sampling `RUN`=1 (1-cycle latency).
- Back-to-back instructions: `uOP` goes k -> 0 on the edge sampling `RESET_uOP`; no bubble.
- Flags visible to the ROM the cycle after capture; a conditional jump therefore sees flags from any earlier instruction.
- Minimal instruction (fetch, decode, boundary at step 2) = 3 cycles.

## Configuration
- `UOP_WATCHDOG_EN` defined: `uOP`=`MAX_UOP` without `RESET_uOP` sets `FAULT`=1 and forces HALTED (`uOP`=7), no count increment; while `FAULT`=1 HALTED cannot exit; cleared only by `RESET`.
- Not defined: that condition is an implicit boundary (counted, normal next-state rules); `FAULT` tied 0.

## Structure
- Shared package `cpu_ctrl_pkg`: step constants `UOP_FETCH`=0, `UOP_DECODE`=1, `UOP_IDLE`=7, `UOP_W`=3, sequencer state enum.
- Sub-module `step_edge_detect`: registers `STEP`, outputs rising-edge pulse; reset value 0.

## Test plan
- Reset, `RUN`=1, `RESET_uOP` pulsed when `uOP`=3 each instruction -> `uOP` 7,0,1,2,3,0,1,2,3...; `INSTR_COUNT` increments every 4 cycles.
- Halted, `RUN`=0, single `STEP` pulse, boundary at `uOP`=4 -> `uOP` 0..4 then 7; `INSTR_COUNT`=1; second `STEP` held high gives no further run.
- `READ_FLAGS`=1 with `ALU_ZERO`=1,`ALU_COUT`=0 at `uOP`=4 -> `ZERO_FLAG`=1,`COUT_FLAG`=0 next cycle; unchanged after halt and re-run until next `READ_FLAGS`.
- `HALT_REQ` raised mid-instruction at `uOP`=2 -> instruction finishes, `uOP`=7, `RUNNING`=0; `RUN`=1 alone cannot restart until `HALT_REQ`=0.
- No `RESET_uOP` for 7 cycles: with `UOP_WATCHDOG_EN` -> `FAULT`=1, `uOP`=7, count unchanged; without -> `uOP` 6 -> 0, `INSTR_COUNT`+1, `FAULT`=0.
- `RESET` asserted asynchronously at `uOP`=3 with `INSTR_COUNT`=`2^COUNT_W-1` -> all outputs to reset values immediately; separate run wraps count from max to 0.
